// File: rtl/branch_rs_pkg.sv
// Shared CPU definitions for the branch reservation station and its resolver:
// branch op encodings (RISC-V funct3, JALR folded in), the unlocked tag and the default data width.
package branch_rs_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int TAG_UNLOCKED = 0;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_JALR = 3'b010,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } br_op_e;

endpackage

// File: rtl/branch_rs_if.sv
// Allocation, CDB, flush and redirect signals of the branch reservation station.
interface branch_rs_if
  import branch_rs_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             alloc_valid;
  logic             alloc_ready;
  logic [2:0]       alloc_op;
  logic [XLEN-1:0]  alloc_pc;
  logic [XLEN-1:0]  alloc_offset;
  logic [TAG_W-1:0] alloc_tagx;
  logic [TAG_W-1:0] alloc_tagy;
  logic [XLEN-1:0]  alloc_datax;
  logic [XLEN-1:0]  alloc_datay;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             flush;
  logic             redir_valid;
  logic             redir_taken;
  logic [XLEN-1:0]  redir_target;
  logic [XLEN-1:0]  redir_pc;
  logic [CW-1:0]    occupancy;

  modport master (
    output alloc_valid, alloc_op, alloc_pc, alloc_offset, alloc_tagx, alloc_tagy,
           alloc_datax, alloc_datay, cdb_valid, cdb_tag, cdb_data, flush,
    input  alloc_ready, redir_valid, redir_taken, redir_target, redir_pc, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_pc, alloc_offset, alloc_tagx, alloc_tagy,
           alloc_datax, alloc_datay, cdb_valid, cdb_tag, cdb_data, flush,
    output alloc_ready, redir_valid, redir_taken, redir_target, redir_pc, occupancy
  );

endinterface

// File: rtl/branch_resolve.sv
// Combinational branch outcome and next-PC computation for one issued entry.
module branch_resolve
  import branch_rs_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] jalr_sum;
  assign jalr_sum = x + offset;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    taken  = 1'b0;
    target = pc + XLEN'(4);
    case (op)
      OP_BEQ:  taken = (x == y);
      OP_BNE:  taken = (x != y);
      OP_BLT:  taken = ($signed(x) <  $signed(y));
      OP_BGE:  taken = ($signed(x) >= $signed(y));
      OP_BLTU: taken = (x <  y);
      OP_BGEU: taken = (x >= y);
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (op == OP_JALR)
      target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (taken)
      target = pc + offset;
  end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: captures operands, wakes on CDB broadcasts, issues the
// oldest ready entry each cycle and registers its redirect.
module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  input logic        rdy,
  branch_rs_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [TAG_W-1:0] UNLOCKED = TAG_W'(TAG_UNLOCKED);

  logic [DEPTH-1:0] valid_q, valid_d, ready;
  logic [IW-1:0]    age_q [DEPTH];
  logic [IW-1:0]    age_d [DEPTH];
  logic [2:0]       op_q [DEPTH];
  logic [XLEN-1:0]  pc_q [DEPTH], off_q [DEPTH], datax_q [DEPTH], datay_q [DEPTH];
  logic [TAG_W-1:0] tagx_q [DEPTH], tagy_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic             alloc_ready, alloc_fire, alloc_found, issue_any, issue_fire, cdb_hit;
  logic [IW-1:0]    alloc_idx, issue_idx;
  logic             res_taken;
  logic [XLEN-1:0]  res_target;
  logic             redir_valid_q, redir_taken_q;
  logic [XLEN-1:0]  redir_target_q, redir_pc_q;
  logic [TAG_W-1:0] cap_tagx, cap_tagy;
  logic [XLEN-1:0]  cap_datax, cap_datay;

  // Slots freed by this cycle's issue only become visible next cycle.
  assign alloc_ready = (count_q < CW'(DEPTH));
  assign alloc_fire  = rdy && bus.alloc_valid && alloc_ready && !bus.flush;
  assign issue_fire  = rdy && !bus.flush && issue_any;
  assign cdb_hit     = bus.cdb_valid && (bus.cdb_tag != UNLOCKED);

  assign cap_tagx  = (bus.alloc_tagx != UNLOCKED && cdb_hit && bus.cdb_tag == bus.alloc_tagx) ? UNLOCKED : bus.alloc_tagx;
  assign cap_tagy  = (bus.alloc_tagy != UNLOCKED && cdb_hit && bus.cdb_tag == bus.alloc_tagy) ? UNLOCKED : bus.alloc_tagy;
  assign cap_datax = (cap_tagx != bus.alloc_tagx) ? bus.cdb_data : bus.alloc_datax;
  assign cap_datay = (cap_tagy != bus.alloc_tagy) ? bus.cdb_data : bus.alloc_datay;

  // Readiness uses registered tags only, so a CDB wakeup issues one cycle later.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    issue_idx   = '0;
    issue_any   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && (tagx_q[i] == UNLOCKED) &&
                 (op_q[i] == OP_JALR || tagy_q[i] == UNLOCKED);
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IW'(i);
        alloc_found = 1'b1;
      end
      if (ready[i] && (!issue_any || age_q[i] > age_q[issue_idx])) begin
        issue_idx = IW'(i);
        issue_any = 1'b1;
      end
    end
  end

  // Oldest entry carries the largest age; ages stay a dense 0..n-1 ranking.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    count_d = count_q + CW'(alloc_fire) - CW'(issue_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (alloc_fire) age_d[i] = age_d[i] + IW'(1);
        if (issue_fire && age_q[i] > age_q[issue_idx]) age_d[i] = age_d[i] - IW'(1);
      end
    end
    if (issue_fire) valid_d[issue_idx] = 1'b0;
    if (alloc_fire) begin
      valid_d[alloc_idx] = 1'b1;
      age_d[alloc_idx]   = '0;
    end
    if (bus.flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  branch_resolve #(.XLEN(XLEN)) u_resolve (
    .op     (op_q[issue_idx]),
    .pc     (pc_q[issue_idx]),
    .offset (off_q[issue_idx]),
    .x      (datax_q[issue_idx]),
    .y      (datay_q[issue_idx]),
    .taken  (res_taken),
    .target (res_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is updated with <= so every register sees pre-edge values.
      valid_q        <= '0;
      count_q        <= '0;
      redir_valid_q  <= 1'b0;
      redir_taken_q  <= 1'b0;
      redir_target_q <= '0;
      redir_pc_q     <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (rdy) begin
      valid_q       <= valid_d;
      age_q         <= age_d;
      count_q       <= count_d;
      redir_valid_q <= issue_fire;
      if (issue_fire) begin
        redir_taken_q  <= res_taken;
        redir_target_q <= res_target;
        redir_pc_q     <= pc_q[issue_idx];
      end
    end
  end

  // NOTE: entry payload is qualified by valid_q, so it is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_hit) begin
          if (tagx_q[i] == bus.cdb_tag) begin
            tagx_q[i]  <= UNLOCKED;
            datax_q[i] <= bus.cdb_data;
          end
          if (tagy_q[i] == bus.cdb_tag) begin
            tagy_q[i]  <= UNLOCKED;
            datay_q[i] <= bus.cdb_data;
          end
        end
      end
      if (alloc_fire) begin
        op_q[alloc_idx]    <= bus.alloc_op;
        pc_q[alloc_idx]    <= bus.alloc_pc;
        off_q[alloc_idx]   <= bus.alloc_offset;
        tagx_q[alloc_idx]  <= cap_tagx;
        tagy_q[alloc_idx]  <= cap_tagy;
        datax_q[alloc_idx] <= cap_datax;
        datay_q[alloc_idx] <= cap_datay;
      end
    end
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.occupancy    = count_q;
  assign bus.redir_valid  = redir_valid_q;
  assign bus.redir_taken  = redir_taken_q;
  assign bus.redir_target = redir_target_q;
  assign bus.redir_pc     = redir_pc_q;

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: a queue-ordered station model predicts each redirect
// (cycle, outcome, target, pc); a monitor compares whenever the DUT pulses redir_valid.
module tb_branch_rs;
  import branch_rs_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pc, off, x, y;
    logic [3:0]  tx, ty;
  } ent_t;

  typedef struct {
    int          due;
    logic        taken;
    logic [31:0] target, pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  ent_t mq[$];
  exp_t exp_q[$];
  logic        last_taken;
  logic [31:0] last_target;

  branch_rs_if #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  branch_rs #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural branch semantics, straight from the ISA rules.
  function automatic exp_t ref_resolve(input ent_t e, input int due);
    exp_t r;
    r.due = due;
    r.pc  = e.pc;
    case (e.op)
      3'b000:  r.taken = (e.x == e.y);
      3'b001:  r.taken = (e.x != e.y);
      3'b100:  r.taken = (int'(e.x) <  int'(e.y));
      3'b101:  r.taken = (int'(e.x) >= int'(e.y));
      3'b110:  r.taken = (e.x <  e.y);
      3'b111:  r.taken = (e.x >= e.y);
      3'b010:  r.taken = 1'b1;
      default: r.taken = 1'b0;
    endcase
    if (e.op == 3'b010) r.target = (e.x + e.off) & 32'hFFFF_FFFE;
    else r.target = r.taken ? e.pc + e.off : e.pc + 32'd4;
    return r;
  endfunction

  // Model of the edge that follows: queue order is allocation order.
  task automatic model_step();
    int   occ0 = mq.size();
    int   k = -1;
    ent_t e;
    if (!rdy) return;
    if (bus.flush) begin
      mq.delete();
      return;
    end
    for (int i = 0; i < mq.size(); i++)
      if (k < 0 && mq[i].tx == 0 && (mq[i].op == 3'b010 || mq[i].ty == 0)) k = i;
    if (k >= 0) begin
      exp_q.push_back(ref_resolve(mq[k], cyc + 1));
      mq.delete(k);
    end
    if (bus.cdb_valid && bus.cdb_tag != 0) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].tx == bus.cdb_tag) begin mq[i].tx = 0; mq[i].x = bus.cdb_data; end
        if (mq[i].ty == bus.cdb_tag) begin mq[i].ty = 0; mq[i].y = bus.cdb_data; end
      end
    end
    if (bus.alloc_valid && occ0 < DEPTH) begin
      e.op = bus.alloc_op; e.pc = bus.alloc_pc; e.off = bus.alloc_offset;
      e.x = bus.alloc_datax; e.y = bus.alloc_datay;
      e.tx = bus.alloc_tagx; e.ty = bus.alloc_tagy;
      if (e.tx != 0 && bus.cdb_valid && bus.cdb_tag == e.tx) begin e.tx = 0; e.x = bus.cdb_data; end
      if (e.ty != 0 && bus.cdb_valid && bus.cdb_tag == e.ty) begin e.ty = 0; e.y = bus.cdb_data; end
      mq.push_back(e);
    end
  endtask

  task automatic idle();
    rdy = 1'b1;
    bus.alloc_valid = 1'b0; bus.alloc_op = '0; bus.alloc_pc = '0; bus.alloc_offset = '0;
    bus.alloc_tagx = '0; bus.alloc_tagy = '0; bus.alloc_datax = '0; bus.alloc_datay = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.flush = 1'b0;
  endtask

  // Called at a falling edge with inputs set; checks registered state, then advances one cycle.
  task automatic tick();
    check("occupancy", bus.occupancy, mq.size());
    check("alloc_ready", bus.alloc_ready, mq.size() < DEPTH);
    model_step();
    @(negedge clk);
  endtask

  task automatic alloc(input logic [2:0] op, input logic [31:0] pc, off,
                       input logic [3:0] tx, ty, input logic [31:0] dx, dy);
    idle();
    bus.alloc_valid = 1'b1; bus.alloc_op = op; bus.alloc_pc = pc; bus.alloc_offset = off;
    bus.alloc_tagx = tx; bus.alloc_tagy = ty; bus.alloc_datax = dx; bus.alloc_datay = dy;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_redir_valid"}, bus.redir_valid, 0);
    check({tag, "_redir_taken"}, bus.redir_taken, 0);
    check({tag, "_redir_target"}, bus.redir_target, 0);
    check({tag, "_redir_pc"}, bus.redir_pc, 0);
    check({tag, "_occupancy"}, bus.occupancy, 0);
    check({tag, "_alloc_ready"}, bus.alloc_ready, 1);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd5;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rand_tag();
    return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
  endfunction

  // Monitor: only edges with rdy high can produce a new redirect pulse.
  initial begin
    exp_t e;
    logic live;
    forever begin
      @(posedge clk);
      cyc++;
      live = rdy && rst_n;
      #1;
      if (live && bus.redir_valid) begin
        if (exp_q.size() == 0) begin
          check("redir_unexpected", bus.redir_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("redir_cycle", cyc, e.due);
          check("redir_pc", bus.redir_pc, e.pc);
          check("redir_taken", bus.redir_taken, e.taken);
          check("redir_target", bus.redir_target, e.target);
          last_taken  = bus.redir_taken;
          last_target = bus.redir_target;
        end
      end
    end
  end

  initial begin
    idle();
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle();

    alloc(OP_BEQ, 32'h100, 32'h20, 0, 0, 5, 5);
    idle(); repeat (3) tick();
    check("beq_taken", last_taken, 1);
    check("beq_target", last_target, 32'h120);

    alloc(OP_BLT, 32'h200, 32'h40, 0, 0, 32'hFFFF_FFFF, 1);
    idle(); repeat (3) tick();
    check("blt_taken", last_taken, 1);
    check("blt_target", last_target, 32'h240);

    alloc(OP_BLTU, 32'h300, 32'h40, 0, 0, 32'hFFFF_FFFF, 1);
    idle(); repeat (3) tick();
    check("bltu_taken", last_taken, 0);
    check("bltu_target", last_target, 32'h304);

    alloc(OP_BNE, 32'h400, 32'h10, 3, 0, 0, 7);
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_data = 32'd7; tick();
    idle(); repeat (3) tick();
    check("bne_taken", last_taken, 0);
    check("bne_target", last_target, 32'h404);

    for (int i = 0; i < DEPTH; i++) alloc(OP_BEQ, 32'h500 + 32'(16 * i), 32'd8, 5, 0, 0, 0);
    check("full_alloc_ready", bus.alloc_ready, 0);
    check("full_occupancy", bus.occupancy, DEPTH);
    alloc(OP_BEQ, 32'h600, 32'd8, 0, 0, 0, 0);
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_data = 32'd0; tick();
    idle(); repeat (DEPTH + 2) tick();

    alloc(OP_JALR, 32'h700, 32'd2, 0, 9, 32'h1001, 0);
    idle(); repeat (3) tick();
    check("jalr_taken", last_taken, 1);
    check("jalr_target", last_target, 32'h1002);

    alloc(OP_BEQ, 32'h800, 32'd4, 6, 0, 1, 1);
    alloc(OP_BNE, 32'h900, 32'd4, 6, 0, 1, 2);
    idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd6; bus.cdb_data = 32'd1; tick();
    idle(); bus.flush = 1'b1; tick();
    idle();
    check("flush_occupancy", bus.occupancy, 0);
    repeat (3) tick();

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        idle();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        mq.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
      rdy = ($urandom_range(0, 7) != 0);
      bus.alloc_valid  = ($urandom_range(0, 9) < 6);
      bus.alloc_op     = 3'($urandom_range(0, 7));
      bus.alloc_pc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      bus.alloc_offset = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : rand_val();
      bus.alloc_tagx   = rand_tag();
      bus.alloc_tagy   = rand_tag();
      bus.alloc_datax  = rand_val();
      bus.alloc_datay  = rand_val();
      bus.cdb_valid    = ($urandom_range(0, 2) != 0);
      bus.cdb_tag      = 4'($urandom_range(0, 3));
      bus.cdb_data     = rand_val();
      bus.flush        = ($urandom_range(0, 39) == 0);
      tick();
    end

    for (int t = 1; t <= 3; t++) begin
      idle(); bus.cdb_valid = 1'b1; bus.cdb_tag = 4'(t); bus.cdb_data = 32'(t); tick();
    end
    idle(); repeat (DEPTH + 4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_occupancy", bus.occupancy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
